pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain_pkg.sv | 22 ++
 rtl/pipe_chain_stage.sv | 32 +++
 rtl/pipe_chain.sv | 126 ++++++++++++
 tb/tb_pipe_chain.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_chain_pkg.sv
// Shared types for the pipe_chain slice: one stage-entry record sized for the
// widest supported configuration (WIDTH <= 64, REGW <= 8), plus counter width.
package pipe_chain_pkg;

  localparam int ENTRY_DATA_W = 64;
  localparam int ENTRY_REG_W  = 8;
  localparam int STALL_CNT_W  = 16;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_REG_W-1:0]  dst;
    logic                    wen;
  } stage_entry_t;

  // Register index 0 is hardwired and never matches anything.
  function automatic logic reg_match(input logic [ENTRY_REG_W-1:0] dst,
                                     input logic [ENTRY_REG_W-1:0] src);
    return (src != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// Single pipeline entry register. Flush beats accept; an accept with no
// incoming entry leaves a bubble, otherwise the stage holds its contents.
module pipe_stage
  import pipe_chain_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_accept,
  input  stage_entry_t i_entry,
  output stage_entry_t o_entry
);

  stage_entry_t r_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entry <= '0;
    end else if (i_flush) begin
      r_entry.valid <= 1'b0;
    end else if (i_accept) begin
      if (i_entry.valid) begin
        r_entry <= i_entry;
      end else begin
        r_entry.valid <= 1'b0;
      end
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/pipe_chain.sv
// Elastic register pipeline with per-stage hold/flush, bubble collapse,
// source-register hazard detection and forwarding selects for the producer.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int STAGES      = 5,
  parameter int WIDTH       = 32,
  parameter int REGW        = 5,
  parameter int READY_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [REGW-1:0]             in_src_a,
  input  logic [REGW-1:0]             in_src_b,
  input  logic [REGW-1:0]             in_dst,
  input  logic                        in_wen,
  input  logic [STAGES-1:0]           stage_hold,
  input  logic [STAGES-1:0]           flush_mask,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [REGW-1:0]             out_dst,
  output logic                        out_wen,
  output logic [$clog2(STAGES+1)-1:0] fwd_sel_a,
  output logic [$clog2(STAGES+1)-1:0] fwd_sel_b,
  output logic [STALL_CNT_W-1:0]      stall_cnt
);

  localparam int SELW = $clog2(STAGES+1);

  stage_entry_t             w_q [STAGES];
  stage_entry_t             w_d [STAGES];
  logic [STAGES-1:0]        w_adv;
  logic [STAGES-1:0]        w_acc;
  logic                     w_hazard;
  logic                     w_in_ready;
  logic [SELW-1:0]          w_fwd_a;
  logic [SELW-1:0]          w_fwd_b;
  logic [ENTRY_REG_W-1:0]   w_src_a;
  logic [ENTRY_REG_W-1:0]   w_src_b;
  logic [STALL_CNT_W-1:0]   r_stall_cnt;
  logic                     w_unused;

  assign w_src_a = ENTRY_REG_W'(in_src_a);
  assign w_src_b = ENTRY_REG_W'(in_src_b);

  // Ready ripples combinationally from the output back to stage 0 so a full
  // pipe still moves one entry per cycle when the consumer is ready.
  always_comb begin
    w_adv = '0;
    w_acc = '0;
    w_adv[STAGES-1] = w_q[STAGES-1].valid && out_ready && !stage_hold[STAGES-1];
    w_acc[STAGES-1] = !w_q[STAGES-1].valid || w_adv[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) begin
      w_adv[i] = w_q[i].valid && !stage_hold[i] && w_acc[i+1];
      w_acc[i] = !w_q[i].valid || w_adv[i];
    end
  end

  // Descending scan so the youngest matching stage wins the forward select.
  always_comb begin
    w_hazard = 1'b0;
    w_fwd_a  = '0;
    w_fwd_b  = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (w_q[i].valid && w_q[i].wen) begin
        if (i < READY_STAGE) begin
          if (reg_match(w_q[i].dst, w_src_a) || reg_match(w_q[i].dst, w_src_b)) begin
            w_hazard = 1'b1;
          end
        end else begin
          if (reg_match(w_q[i].dst, w_src_a)) w_fwd_a = SELW'(i + 1);
          if (reg_match(w_q[i].dst, w_src_b)) w_fwd_b = SELW'(i + 1);
        end
      end
    end
  end

  assign w_in_ready = w_acc[0] && !w_hazard && !flush_mask[0];

  always_comb begin
    w_d[0].valid = in_valid && w_in_ready;
    w_d[0].data  = ENTRY_DATA_W'(in_data);
    w_d[0].dst   = ENTRY_REG_W'(in_dst);
    w_d[0].wen   = in_wen;
    for (int i = 1; i < STAGES; i++) begin
      w_d[i]       = w_q[i-1];
      w_d[i].valid = w_adv[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage u_stage (
      .clk      (clk),
      .reset    (reset),
      .i_flush  (flush_mask[g]),
      .i_accept (w_acc[g]),
      .i_entry  (w_d[g]),
      .o_entry  (w_q[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !w_in_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_q[STAGES-1].valid;
  assign out_data  = w_q[STAGES-1].data[WIDTH-1:0];
  assign out_dst   = w_q[STAGES-1].dst[REGW-1:0];
  assign out_wen   = w_q[STAGES-1].wen;
  assign fwd_sel_a = w_fwd_a;
  assign fwd_sel_b = w_fwd_b;
  assign stall_cnt = r_stall_cnt;

  // Entry record is sized for the widest configuration; high bits are idle.
  assign w_unused = ^{w_q[STAGES-1].data, w_q[STAGES-1].dst};

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: forwarding/hazard vector table, hand-built multi-cycle
// sequences, and a randomized run against a queue-based occupancy model.
module tb_pipe_chain;

  localparam int STAGES      = 5;
  localparam int WIDTH       = 32;
  localparam int REGW        = 5;
  localparam int READY_STAGE = 2;
  localparam int SELW        = $clog2(STAGES+1);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [REGW-1:0]   in_src_a;
  logic [REGW-1:0]   in_src_b;
  logic [REGW-1:0]   in_dst;
  logic              in_wen;
  logic [STAGES-1:0] stage_hold;
  logic [STAGES-1:0] flush_mask;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [REGW-1:0]   out_dst;
  logic              out_wen;
  logic [SELW-1:0]   fwd_sel_a;
  logic [SELW-1:0]   fwd_sel_b;
  logic [15:0]       stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_chain #(
    .STAGES(STAGES), .WIDTH(WIDTH), .REGW(REGW), .READY_STAGE(READY_STAGE)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst), .in_wen(in_wen),
    .stage_hold(stage_hold), .flush_mask(flush_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dst(out_dst), .out_wen(out_wen),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = '0; in_src_a = '0; in_src_b = '0;
    in_dst = '0; in_wen = 1'b0; stage_hold = '0; flush_mask = '0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic offer(input logic [WIDTH-1:0] d, input logic [REGW-1:0] dst, input logic wen,
                       input logic [REGW-1:0] sa, input logic [REGW-1:0] sb);
    in_valid = 1'b1; in_data = d; in_dst = dst; in_wen = wen; in_src_a = sa; in_src_b = sb;
  endtask

  // Holds the offer until it is taken; returns stall cycles and the forward selects seen then.
  task automatic offer_until_accepted(input logic [WIDTH-1:0] d, input logic [REGW-1:0] dst,
                                      input logic wen, input logic [REGW-1:0] sa,
                                      input logic [REGW-1:0] sb, output int stalls,
                                      output logic [SELW-1:0] fa, output logic [SELW-1:0] fb);
    logic got;
    got = 1'b0; stalls = 0; fa = '0; fb = '0;
    for (int c = 0; c < 12 && !got; c++) begin
      offer(d, dst, wen, sa, sb);
      #1;
      if (in_ready) begin
        got = 1'b1; fa = fwd_sel_a; fb = fwd_sel_b;
      end else begin
        stalls++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic fill_pipe(output int acc);
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      offer(WIDTH'(32'h100 + acc), REGW'(acc + 1), 1'b0, '0, '0);
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input logic [WIDTH-1:0] base, output int got);
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      #1;
      if (out_valid) begin
        check("drain_data", out_data, base + WIDTH'(got));
        got++;
      end
      tick();
    end
  endtask

  // ---------------- reference model for the random run ----------------
  typedef struct {
    int               pos;
    logic [WIDTH-1:0] data;
    logic [REGW-1:0]  dst;
    logic             wen;
  } m_ent_t;

  task automatic run_random(input int n_cycles);
    m_ent_t mq[$];
    int     m_stall;
    m_stall = 0;
    do_reset();
    for (int c = 0; c < n_cycles; c++) begin
      logic   ov, fire, haz, acc0, exp_rdy;
      int     fa, fb, rem, np;
      m_ent_t e;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      in_src_a  = REGW'($urandom_range(0, 7));
      in_src_b  = REGW'($urandom_range(0, 7));
      in_dst    = REGW'($urandom_range(0, 7));
      in_wen    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      // Entries are kept oldest first with their stage number.
      ov   = (mq.size() > 0) && (mq[0].pos == STAGES-1);
      fire = ov && out_ready;
      haz = 1'b0; fa = 0; fb = 0;
      foreach (mq[k]) begin
        if (mq[k].wen && mq[k].dst != 0) begin
          if (mq[k].pos < READY_STAGE) begin
            if (mq[k].dst == in_src_a || mq[k].dst == in_src_b) haz = 1'b1;
          end else begin
            if (mq[k].dst == in_src_a && (fa == 0 || mq[k].pos + 1 < fa)) fa = mq[k].pos + 1;
            if (mq[k].dst == in_src_b && (fb == 0 || mq[k].pos + 1 < fb)) fb = mq[k].pos + 1;
          end
        end
      end
      acc0 = 1'b1; rem = 0;
      foreach (mq[k]) begin
        if (!(fire && k == 0)) begin
          np = (mq[k].pos + 1 < STAGES-1-rem) ? mq[k].pos + 1 : STAGES-1-rem;
          if (np == 0) acc0 = 1'b0;
          rem++;
        end
      end
      exp_rdy = acc0 && !haz;
      #1;
      check("rnd_in_ready", in_ready, exp_rdy);
      check("rnd_out_valid", out_valid, ov);
      if (ov) begin
        check("rnd_out_data", out_data, mq[0].data);
        check("rnd_out_dst", out_dst, mq[0].dst);
        check("rnd_out_wen", out_wen, mq[0].wen);
      end
      check("rnd_fwd_a", fwd_sel_a, fa);
      check("rnd_fwd_b", fwd_sel_b, fb);
      check("rnd_stall_cnt", stall_cnt, m_stall);
      if (in_valid && !exp_rdy && m_stall < 65535) m_stall++;
      if (fire) void'(mq.pop_front());
      for (int k = 0; k < mq.size(); k++) begin
        mq[k].pos = (mq[k].pos + 1 < STAGES-1-k) ? mq[k].pos + 1 : STAGES-1-k;
      end
      if (in_valid && exp_rdy) begin
        e.pos = 0; e.data = in_data; e.dst = in_dst; e.wen = in_wen;
        mq.push_back(e);
      end
      tick();
    end
    idle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [REGW-1:0] dst;
    logic            wen;
    int              stage;
    logic [REGW-1:0] src_a;
    logic [REGW-1:0] src_b;
    logic            exp_ready;
    logic [SELW-1:0] exp_fa;
    logic [SELW-1:0] exp_fb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int              acc, got, stalls;
    logic [SELW-1:0] fa, fb;

    vecs[0] = '{5'd7,  1'b1, 0, 5'd7,  5'd0,  1'b0, 3'd0, 3'd0};
    vecs[1] = '{5'd7,  1'b1, 1, 5'd0,  5'd7,  1'b0, 3'd0, 3'd0};
    vecs[2] = '{5'd7,  1'b1, 2, 5'd7,  5'd0,  1'b1, 3'd3, 3'd0};
    vecs[3] = '{5'd7,  1'b1, 3, 5'd0,  5'd7,  1'b1, 3'd0, 3'd4};
    vecs[4] = '{5'd7,  1'b1, 4, 5'd7,  5'd7,  1'b1, 3'd5, 3'd5};
    vecs[5] = '{5'd0,  1'b1, 0, 5'd0,  5'd0,  1'b1, 3'd0, 3'd0};
    vecs[6] = '{5'd0,  1'b1, 3, 5'd0,  5'd0,  1'b1, 3'd0, 3'd0};
    vecs[7] = '{5'd7,  1'b0, 0, 5'd7,  5'd7,  1'b1, 3'd0, 3'd0};
    vecs[8] = '{5'd7,  1'b1, 0, 5'd6,  5'd5,  1'b1, 3'd0, 3'd0};
    vecs[9] = '{5'd31, 1'b1, 2, 5'd31, 5'd30, 1'b1, 3'd3, 3'd0};

    // Reset state, sampled while reset is held.
    idle();
    reset = 1'b1;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_fwd_a", fwd_sel_a, '0);
    check("rst_fwd_b", fwd_sel_b, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Forwarding / hazard table: one producer parked at a given stage, then probed.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      offer(32'h00A0, vecs[v].dst, vecs[v].wen, '0, '0);
      tick();
      in_valid = 1'b0;
      for (int s = 0; s < vecs[v].stage; s++) tick();
      offer(32'h00B0, '0, 1'b0, vecs[v].src_a, vecs[v].src_b);
      #1;
      check($sformatf("vec%0d_in_ready", v), in_ready, vecs[v].exp_ready);
      check($sformatf("vec%0d_fwd_a", v), fwd_sel_a, vecs[v].exp_fa);
      check($sformatf("vec%0d_fwd_b", v), fwd_sel_b, vecs[v].exp_fb);
      in_valid = 1'b0;
    end

    // Single-entry latency.
    do_reset();
    offer(32'h1234, 5'd3, 1'b1, '0, '0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("lat_out_valid_c%0d", k + 1), out_valid, (k == 4));
      if (k == 4) begin
        check("lat_out_data", out_data, 32'h1234);
        check("lat_out_dst", out_dst, 5'd3);
        check("lat_out_wen", out_wen, 1'b1);
      end
      tick();
    end

    // Back-to-back stream of 8 entries.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c < 8) offer(WIDTH'(c + 1), '0, 1'b0, '0, '0);
      else in_valid = 1'b0;
      #1;
      if (c < 8) check($sformatf("b2b_in_ready_c%0d", c), in_ready, 1'b1);
      check($sformatf("b2b_out_valid_c%0d", c), out_valid, (c >= 5 && c <= 12));
      if (c >= 5 && c <= 12) check($sformatf("b2b_out_data_c%0d", c), out_data, WIDTH'(c - 4));
      tick();
    end

    // Hazard stall then forward from stage 2.
    do_reset();
    offer_until_accepted(32'h0001, 5'd7, 1'b1, '0, '0, stalls, fa, fb);
    offer_until_accepted(32'h0002, 5'd1, 1'b0, 5'd7, '0, stalls, fa, fb);
    check("haz_stalls", stalls, 2);
    check("haz_fwd_a", fa, 3'd3);
    #1;
    check("haz_stall_cnt", stall_cnt, 16'd2);

    // Backpressure fill then in-order drain.
    do_reset();
    fill_pipe(acc);
    check("fill_accepted", acc, 5);
    in_valid = 1'b1;
    #1;
    check("fill_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    drain(10, 32'h100, got);
    check("drain_count", got, 5);

    // Flush of the three youngest stages of a full pipe.
    do_reset();
    fill_pipe(acc);
    flush_mask = 5'b00111;
    tick();
    flush_mask = '0;
    #1;
    check("flush_out_valid", out_valid, 1'b1);
    check("flush_in_ready", in_ready, 1'b1);
    drain(10, 32'h100, got);
    check("flush_count", got, 2);

    // Hold on stage 2 for two cycles delays the entry by two cycles.
    do_reset();
    offer(32'h0077, '0, 1'b0, '0, '0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    stage_hold = 5'b00100;
    tick();
    tick();
    stage_hold = '0;
    #1;
    check("hold_out_valid_held", out_valid, 1'b0);
    tick();
    #1;
    check("hold_out_valid_c6", out_valid, 1'b0);
    tick();
    #1;
    check("hold_out_valid_c7", out_valid, 1'b1);
    check("hold_out_data", out_data, 32'h0077);

    // Asynchronous reset with three entries in flight.
    do_reset();
    offer_until_accepted(32'h0A, 5'd9, 1'b1, '0, '0, stalls, fa, fb);
    offer_until_accepted(32'h0B, 5'd0, 1'b0, 5'd9, '0, stalls, fa, fb);
    offer_until_accepted(32'h0C, 5'd0, 1'b0, '0, '0, stalls, fa, fb);
    #1;
    check("inflight_out_valid", out_valid, 1'b1);
    check("inflight_stall_cnt", stall_cnt, 16'd2);
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_stall_cnt", stall_cnt, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("post_rst_out_valid_c%0d", c), out_valid, 1'b0);
      tick();
    end

    run_random(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
